// File: rtl/bit_op_pkg.sv
// Shared definitions for the bit-addressable memory sequencer:
// op-code values, FSM state encoding and the read-requirement decode.
package bit_op_pkg;

  localparam logic [2:0] OP_CLR   = 3'd0;
  localparam logic [2:0] OP_SETB  = 3'd1;
  localparam logic [2:0] OP_CPL   = 3'd2;
  localparam logic [2:0] OP_MOVCB = 3'd3;
  localparam logic [2:0] OP_MOVBC = 3'd4;
  localparam logic [2:0] OP_ANL   = 3'd5;
  localparam logic [2:0] OP_ORL   = 3'd6;
  localparam logic [2:0] OP_ANLN  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EX   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Only CLR, SETB and MOV bit,C can write without looking at the cell first.
  function automatic logic needs_read(input logic [2:0] op);
    return !(op == OP_CLR || op == OP_SETB || op == OP_MOVBC);
  endfunction

endpackage

// File: rtl/bit_op_ctrl_alu.sv
// Combinational bit ALU: write data for the memory cell and next carry value,
// from the op code, the bit read (r) and the current carry (c).
module bit_alu
  import bit_op_pkg::*;
(
  input  logic [2:0] op,
  input  logic       r,
  input  logic       c,
  output logic       wdata,
  output logic       c_next
);

  always_comb begin
    wdata  = r;
    c_next = c;
    case (op)
      OP_CLR:   wdata  = 1'b0;
      OP_SETB:  wdata  = 1'b1;
      OP_CPL:   wdata  = ~r;
      OP_MOVCB: c_next = r;
      OP_MOVBC: wdata  = c;
      OP_ANL:   c_next = c & r;
      OP_ORL:   c_next = c | r;
      OP_ANLN:  c_next = c & ~r;
      default:  wdata  = r;
    endcase
  end

endmodule

// File: rtl/bit_op_ctrl.sv
// Single-bit memory sequencer: accepts one bit instruction at a time, runs the
// read / modify / write sequence against the bit memory and owns the carry flag.
module bit_op_ctrl
  import bit_op_pkg::*;
#(
  parameter int ADDRWIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic [2:0]           op,
  input  logic [ADDRWIDTH-1:0] bit_addr,
  output logic                 ready,
  output logic                 done,
  output logic                 bit_val,
  output logic                 c_flag,
  input  logic                 c_load,
  input  logic                 c_din,
  output logic                 mem_cs_n,
  output logic                 mem_rw,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic                 mem_din,
  input  logic                 mem_dout
);

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic [2:0] alu_op;
  logic       alu_wdata;
  logic       alu_c_next;
  logic       accept;

  assign accept = req && ready;

  // In IDLE the ALU sees the incoming op so write-only ops get their data at accept.
  assign alu_op = (state == S_IDLE) ? op : op_q;

  bit_alu u_alu (
    .op     (alu_op),
    .r      (mem_dout),
    .c      (c_flag),
    .wdata  (alu_wdata),
    .c_next (alu_c_next)
  );

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (req) state_nxt = needs_read(op) ? S_RD : S_WR;
      end
      S_RD:    state_nxt = S_EX;
      S_EX:    state_nxt = (op_q == OP_CPL) ? S_WR : S_DONE;
      S_WR:    state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory strobes are registered from the next state so they line up with RD/WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bit_val  <= 1'b0;
      c_flag   <= 1'b0;
      mem_cs_n <= 1'b1;
      mem_rw   <= 1'b1;
      mem_addr <= '0;
      mem_din  <= 1'b0;
    end else begin
      state    <= state_nxt;
      mem_cs_n <= !(state_nxt == S_RD || state_nxt == S_WR);
      mem_rw   <= (state_nxt != S_WR);
      if (accept) mem_addr <= bit_addr;
      if (state_nxt == S_WR) mem_din <= alu_wdata;
      if (state == S_EX) bit_val <= mem_dout;
      if (state == S_WR) bit_val <= mem_din;
      if (c_load) c_flag <= c_din;
      else if (state == S_EX) c_flag <= alu_c_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) op_q <= op;
  end

endmodule

// File: tb/tb_bit_op_ctrl.sv
// Scoreboard bench for bit_op_ctrl with a behavioural bit-memory and ISA-level model.
module tb_bit_op_ctrl;
  import bit_op_pkg::*;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [AW-1:0] bit_addr = '0;
  logic          c_load = 1'b0;
  logic          c_din = 1'b0;
  logic          ready, done, bit_val, c_flag;
  logic          mem_cs_n, mem_rw, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;

  bit_op_ctrl #(.ADDRWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .bit_addr(bit_addr),
    .ready(ready), .done(done), .bit_val(bit_val), .c_flag(c_flag),
    .c_load(c_load), .c_din(c_din), .mem_cs_n(mem_cs_n), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit memory: registered read data, noise on the bus when not reading.
  logic mem [DEPTH] = '{default: 1'b0};
  logic dout_q = 1'b0;
  always @(posedge clk) begin
    if (!mem_cs_n && !mem_rw) mem[mem_addr] <= mem_din;
    dout_q <= (!mem_cs_n && mem_rw) ? mem[mem_addr] : 1'($urandom);
  end
  assign mem_dout = dout_q;

  // Reference model state at instruction level.
  logic mref [DEPTH];
  logic cref;

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic          bv;
    logic          cy;
    logic          mv;
    int            lat;
    int            wr;
    int            rd;
    int            acc;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic [2:0] o, input logic [AW-1:0] a, output exp_t e);
    e.op = o; e.addr = a; e.rd = 1; e.wr = 0; e.lat = 3;
    case (o)
      OP_CLR:   begin mref[a] = 1'b0; e.bv = 1'b0; end
      OP_SETB:  begin mref[a] = 1'b1; e.bv = 1'b1; end
      OP_CPL:   begin e.bv = ~mref[a]; mref[a] = e.bv; end
      OP_MOVCB: begin e.bv = mref[a]; cref = mref[a]; end
      OP_MOVBC: begin e.bv = cref; mref[a] = cref; end
      OP_ANL:   begin e.bv = mref[a]; cref = cref & mref[a]; end
      OP_ORL:   begin e.bv = mref[a]; cref = cref | mref[a]; end
      default:  begin e.bv = mref[a]; cref = cref & ~mref[a]; end
    endcase
    if (o == OP_CLR || o == OP_SETB || o == OP_MOVBC) begin
      e.rd = 0; e.wr = 1; e.lat = 2;
    end else if (o == OP_CPL) begin
      e.wr = 1; e.lat = 4;
    end
    e.cy = cref;
    e.mv = mref[a];
  endtask

  // Monitor: pops one expectation per done pulse.
  int  wr_cnt = 0;
  int  rd_cnt = 0;
  bit  rdy_bad = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_cnt = 0; rd_cnt = 0; rdy_bad = 1'b0;
      end else begin
        if (!mem_cs_n && !mem_rw) wr_cnt++;
        if (!mem_cs_n && mem_rw) rd_cnt++;
        if (sbq.size() > 0 && ready) rdy_bad = 1'b1;
        if (done) begin
          if (sbq.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sbq.pop_front();
            check($sformatf("bit_val op%0d a%0d", e.op, e.addr), bit_val, e.bv);
            check($sformatf("c_flag op%0d a%0d", e.op, e.addr), c_flag, e.cy);
            check($sformatf("mem_cell op%0d a%0d", e.op, e.addr), mem[e.addr], e.mv);
            check($sformatf("latency op%0d", e.op), cyc + 1 - e.acc, e.lat);
            check($sformatf("write_cycles op%0d", e.op), wr_cnt, e.wr);
            check($sformatf("read_cycles op%0d", e.op), rd_cnt, e.rd);
            check($sformatf("ready_low_busy op%0d", e.op), int'(rdy_bad), 0);
          end
          wr_cnt = 0; rd_cnt = 0; rdy_bad = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [AW-1:0] a,
                       input bit keep_req, input int cl_ex);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    req = 1'b1; op = o; bit_addr = a;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("accept_timeout", 0, 1);
      req = 1'b0;
      return;
    end
    model(o, a, e);
    if (cl_ex >= 0) begin
      cref = cl_ex[0];
      e.cy = cref;
    end
    e.acc = cyc + 1;
    last_acc = e.acc;
    @(posedge clk);
    sbq.push_back(e);
    if (!keep_req) begin
      @(negedge clk);
      req = 1'b0;
    end
    if (cl_ex >= 0) begin
      @(negedge clk);
      c_load = 1'b1; c_din = cl_ex[0];
      @(negedge clk);
      c_load = 1'b0;
    end
  endtask

  task automatic set_c(input logic v);
    @(negedge clk);
    c_load = 1'b1; c_din = v;
    @(negedge clk);
    c_load = 1'b0;
    cref = v;
    check("c_load_write", c_flag, v);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", 0, 1);
      sbq.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_bit_val"}, bit_val, 0);
    check({tag, "_c_flag"}, c_flag, 0);
    check({tag, "_cs_n"}, mem_cs_n, 1);
    check({tag, "_rw"}, mem_rw, 1);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_din"}, mem_din, 0);
  endtask

  initial begin
    int a1;
    int n;
    for (int i = 0; i < DEPTH; i++) mref[i] = 1'b0;
    cref = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    issue(OP_SETB, 3'd5, 1'b0, -1);
    drain();

    issue(OP_SETB, 3'd2, 1'b0, -1);
    issue(OP_CPL, 3'd2, 1'b0, -1);
    drain();

    set_c(1'b1);
    issue(OP_SETB, 3'd3, 1'b0, -1);
    issue(OP_ANLN, 3'd3, 1'b0, -1);
    issue(OP_ORL, 3'd3, 1'b0, -1);
    drain();

    issue(OP_SETB, 3'd4, 1'b0, -1);
    issue(OP_MOVCB, 3'd4, 1'b0, 0);
    drain();

    set_c(1'b1);
    issue(OP_CLR, 3'd7, 1'b1, -1);
    a1 = last_acc;
    issue(OP_MOVBC, 3'd7, 1'b0, -1);
    check("b2b_accept_spacing", last_acc - a1, 3);
    drain();
    check("b2b_final_bit7", mem[7], 1);

    // Reset in the middle of a write: the cell must keep its old value.
    issue(OP_SETB, 3'd6, 1'b0, -1);
    drain();
    @(negedge clk);
    req = 1'b1; op = OP_CLR; bit_addr = 3'd6;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("wr_cycle_cs_n", mem_cs_n, 0);
    check("wr_cycle_rw", mem_rw, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midop_reset");
    cref = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abandoned_write_bit6", mem[6], 1);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        req = 1'b0;
        drain();
        set_c(1'($urandom));
      end
      issue(3'($urandom_range(0, 7)), AW'($urandom_range(0, DEPTH - 1)),
            ($urandom_range(0, 2) == 0), -1);
    end
    @(negedge clk);
    req = 1'b0;
    drain();

    for (int i = 0; i < DEPTH; i++) check($sformatf("final_mem%0d", i), mem[i], mref[i]);
    check("final_c_flag", c_flag, cref);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
